rs232_tx_scheduler: RTL and testbench
=====================================

// Module: rs232_tx_scheduler
// PURPOSE
// Avalon-MM master that shares the RS232 UART transmit path among NUM_REQ byte requesters.
// Polls the UART control register (address 1) for write_space, holds that as a credit count,
// arbitrates requesters round-robin at packet granularity, and writes granted bytes to the
// data register (address 0). Sits between on-chip byte sources and the UART slave port.
// PARAMETERS
// NUM_REQ    4  number of requesters (2..8)
// POLL_GAP   3  idle cycles after the last write before a poll read is issued (covers UART write latency)
// PORTS
// clk            in   1          system clock
// reset_n        in   1          synchronous reset, active low
// enable         in   1          0: no new packet grants (a packet already granted runs to completion)
// req_valid      in   NUM_REQ    requester i has a byte on req_data[8i+7:8i]
// req_data       in   8*NUM_REQ  byte per requester
// req_last       in   NUM_REQ    byte presented is the last of its packet
// req_ready      out  NUM_REQ    one-cycle pulse: byte of requester i accepted this cycle
// uart_address   out  1          Avalon address to UART (0 data, 1 control)
// uart_chipselect out 1          Avalon chipselect
// uart_byteenable out 4          Avalon byteenable
// uart_read      out  1          Avalon read
// uart_write     out  1          Avalon write
// uart_writedata out  32         Avalon writedata
// uart_readdata  in   32         Avalon readdata (registered in UART, valid 1 cycle after read)
// grant_id       out  3          index of current/last granted requester
// busy           out  1          state != IDLE
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): state=IDLE, credits=0, rr pointer=0, lock=0, gap counter=0; all outputs 0.
//   Reset mid-transaction abandons it immediately; no partial write is issued afterwards.
// - Every output is registered. uart_* are driven only in RD and WR states, otherwise all 0.
// - States: IDLE, RD, RDW, ARB, WR, GAP.
//   IDLE: if any req_valid (and enable, or lock set): credits==0 -> RD, else -> ARB.
//   RD (1 cycle): chipselect=1, read=1, address=1, byteenable=4'b0000 (never pops RX FIFO).
//   RDW (1 cycle): credits <= uart_readdata[23:16] (write_space). -> ARB if credits would be
//   nonzero, else -> GAP (re-poll after POLL_GAP).
//   ARB (1 cycle): if lock: serve locked requester only; if its req_valid=0, wait in ARB.
//   Else select first i with req_valid starting from rr pointer (wrapping at NUM_REQ-1 -> 0);
//   none valid -> IDLE. On selection: req_ready[i]=1 for this cycle, latch byte, grant_id=i,
//   lock <= ~req_last[i]; if req_last[i], rr pointer <= i+1 (mod NUM_REQ). -> WR.
//   WR (1 cycle): chipselect=1, write=1, address=0, byteenable=4'b0001, writedata={24'h0,byte};
//   credits <= credits-1. Next: credits-1 > 0 and (lock or any valid) -> ARB; else -> GAP.
//   GAP: count POLL_GAP cycles, then -> RD if a request is pending (credits==0) or ARB if credits>0;
//   -> IDLE if nothing pending.
// - Throughput: one byte per 2 cycles while credits last.
// - Credits never underflow: no WR issued with credits==0; UART FIFO can never overflow.
// - Simultaneous valid: round-robin fair; a requester holding a packet is never preempted.
// - enable=0 with lock set: locked packet completes; no further packets granted.
// - Requester must hold req_valid/data/last stable until req_ready; dropping req_valid
//   is legal only when not locked.
// TESTING
// 1 Reset: hold reset_n=0 5 cycles with req_valid=4'hF -> all outputs 0, no read/write issued.
// 2 Single byte: readdata[23:16]=8'd128, req0 sends 8'h41 last=1 -> one read addr1, then
//   write addr0 writedata=32'h41, byteenable=4'b0001, req_ready[0] one pulse.
// 3 Round robin: all 4 valid, 1-byte packets -> grant order 0,1,2,3,0; grant_id matches.
// 4 Packet lock: req1 3-byte packet (last on 3rd) with req2 valid -> 3 req1 writes, then req2.
// 5 Credit exhaustion: write_space=2, req0 sends 5 bytes -> 2 writes, GAP of POLL_GAP cycles,
//   re-poll; write_space=0 -> no write, repoll until write_space=3 -> remaining 3 written.
// 6 Reset mid-WR with lock set -> next cycle all outputs 0, state IDLE, lock cleared.

Source files
------------

// File: rtl/rs232_tx_scheduler.sv
// Avalon-MM master sharing the RS232 UART transmit path among NUM_REQ byte sources.
// Polls write_space into a credit count, grants round-robin per packet, writes one byte per grant.
module rs232_tx_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int POLL_GAP = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_address,
  output logic                 uart_chipselect,
  output logic [3:0]           uart_byteenable,
  output logic                 uart_read,
  output logic                 uart_write,
  output logic [31:0]          uart_writedata,
  input  logic [31:0]          uart_readdata,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_ARB,
    S_WR,
    S_GAP
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       credits, credits_nx;
  logic [2:0]       rr_ptr, rr_nx;
  logic             lock, lock_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic [2:0]       grant_nx;
  logic [NUM_REQ-1:0] ready_nx;
  logic [7:0]       byte_nx;
  logic             grant_go;
  logic [2:0]       sel_idx;
  logic [3:0]       pick;
  logic             pending;

  // Requester vectors padded to the 3-bit index space so any grant_id indexes cleanly
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;
  logic [7:0]  write_space;
  logic        unused_readdata;

  assign valid_pad       = 8'(req_valid);
  assign last_pad        = 8'(req_last);
  assign data_pad        = 64'(req_data);
  assign write_space     = uart_readdata[23:16];
  assign unused_readdata = ^{uart_readdata[31:24], uart_readdata[15:0]};
  assign pending         = lock || (enable && (|req_valid));

  function automatic logic [3:0] rr_pick(input logic [7:0] valid, input logic [2:0] start);
    logic [2:0] idx;
    rr_pick = 4'h0;
    idx     = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (valid[idx] && !rr_pick[3]) rr_pick = {1'b1, idx};
      idx = (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
    end
  endfunction

  assign pick = rr_pick(valid_pad, rr_ptr);

  always_comb begin
    state_nx   = state;
    credits_nx = credits;
    rr_nx      = rr_ptr;
    lock_nx    = lock;
    gap_nx     = gap_cnt;
    grant_nx   = grant_id;
    ready_nx   = '0;
    byte_nx    = 8'h00;
    grant_go   = 1'b0;
    sel_idx    = 3'd0;
    case (state)
      S_IDLE: begin
        if ((|req_valid) && (enable || lock))
          state_nx = (credits == 8'd0) ? S_RD : S_ARB;
      end
      S_RD: state_nx = S_RDW;
      S_RDW: begin
        credits_nx = write_space;
        gap_nx     = '0;
        state_nx   = (write_space != 8'd0) ? S_ARB : S_GAP;
      end
      S_ARB: begin
        // A locked packet is never preempted; wait here until its owner presents the next byte
        if (lock) begin
          grant_go = valid_pad[grant_id];
          sel_idx  = grant_id;
        end else if (enable && pick[3]) begin
          grant_go = 1'b1;
          sel_idx  = pick[2:0];
        end else begin
          state_nx = S_IDLE;
        end
        if (grant_go) begin
          state_nx = S_WR;
          grant_nx = sel_idx;
          ready_nx = NUM_REQ'(8'd1 << sel_idx);
          byte_nx  = data_pad[{sel_idx, 3'b000} +: 8];
          lock_nx  = ~last_pad[sel_idx];
          if (last_pad[sel_idx])
            rr_nx = (sel_idx == 3'(NUM_REQ - 1)) ? 3'd0 : sel_idx + 3'd1;
        end
      end
      S_WR: begin
        credits_nx = credits - 8'd1;
        gap_nx     = '0;
        state_nx   = ((credits > 8'd1) && pending) ? S_ARB : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
          if (!pending)               state_nx = S_IDLE;
          else if (credits == 8'd0)   state_nx = S_RD;
          else                        state_nx = S_ARB;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the RD/WR cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      credits         <= 8'd0;
      rr_ptr          <= 3'd0;
      lock            <= 1'b0;
      gap_cnt         <= '0;
      grant_id        <= 3'd0;
      req_ready       <= '0;
      uart_address    <= 1'b0;
      uart_chipselect <= 1'b0;
      uart_byteenable <= 4'b0000;
      uart_read       <= 1'b0;
      uart_write      <= 1'b0;
      uart_writedata  <= 32'h0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nx;
      credits         <= credits_nx;
      rr_ptr          <= rr_nx;
      lock            <= lock_nx;
      gap_cnt         <= gap_nx;
      grant_id        <= grant_nx;
      req_ready       <= ready_nx;
      uart_address    <= (state_nx == S_RD);
      uart_chipselect <= (state_nx == S_RD) || (state_nx == S_WR);
      uart_byteenable <= (state_nx == S_WR) ? 4'b0001 : 4'b0000;
      uart_read       <= (state_nx == S_RD);
      uart_write      <= (state_nx == S_WR);
      uart_writedata  <= {24'h0, byte_nx};
      busy            <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_rs232_tx_scheduler.sv
// Directed bench for rs232_tx_scheduler: queued requesters, UART bus logging, hand-computed expectations.
module tb_rs232_tx_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int POLL_GAP = 3;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enable = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_address;
  logic                 uart_chipselect;
  logic [3:0]           uart_byteenable;
  logic                 uart_read;
  logic                 uart_write;
  logic [31:0]          uart_writedata;
  logic [31:0]          uart_readdata;
  logic [2:0]           grant_id;
  logic                 busy;

  logic [7:0]  ws = 8'd0;
  logic        hold_all = 1'b0;
  logic [63:0] outs;

  assign uart_readdata = {8'hA5, ws, 16'h5A3C};
  assign outs = {16'h0, uart_address, uart_chipselect, uart_byteenable, uart_read, uart_write,
                 uart_writedata, req_ready, grant_id, busy};

  rs232_tx_scheduler #(.NUM_REQ(NUM_REQ), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_address(uart_address), .uart_chipselect(uart_chipselect),
    .uart_byteenable(uart_byteenable), .uart_read(uart_read), .uart_write(uart_write),
    .uart_writedata(uart_writedata), .uart_readdata(uart_readdata),
    .grant_id(grant_id), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Per-requester byte queues: main appends at tail, requester process pops on req_ready
  logic [7:0] q_data [NUM_REQ][64];
  logic       q_last [NUM_REQ][64];
  int         q_head [NUM_REQ] = '{default: 0};
  int         q_tail [NUM_REQ] = '{default: 0};

  // Bus log
  int         cyc = 0;
  int         wr_cnt = 0, rd_cnt = 0, rdy_cnt = 0;
  logic [31:0] wr_data [64];
  logic [2:0]  wr_gid  [64];
  logic        wr_addr [64];
  logic [3:0]  wr_be   [64];
  int          wr_cyc  [64];
  logic        rd_addr [64];
  logic [3:0]  rd_be   [64];
  int          rd_cyc  [64];
  logic [3:0]  rdy_vec [64];
  int          rdy_cyc [64];

  int n_chk = 0, n_err = 0;

  logic [7:0] t4_data [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hC0};
  logic [2:0] t4_id   [5] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    q_data[r][q_tail[r]] = d;
    q_last[r][q_tail[r]] = l;
    q_tail[r]++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (wr_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("write_wait", 64'(wr_cnt >= target), 64'd1);
  endtask

  task automatic wait_reads(input int target);
    int n = 0;
    while (rd_cnt < target && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("read_wait", 64'(rd_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic wait_write_strobe();
    int n = 0;
    while (uart_write !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("write_strobe", 64'(uart_write), 64'd1);
  endtask

  // Requesters
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] === 1'b1) q_head[i]++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (q_head[i] < q_tail[i]) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = q_data[i][q_head[i]];
          req_last[i]        = q_last[i][q_head[i]];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      if (hold_all) req_valid = '1;
    end
  end

  // Bus monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    if (uart_chipselect === 1'b1 && uart_write === 1'b1 && wr_cnt < 64) begin
      wr_data[wr_cnt] = uart_writedata;
      wr_gid[wr_cnt]  = grant_id;
      wr_addr[wr_cnt] = uart_address;
      wr_be[wr_cnt]   = uart_byteenable;
      wr_cyc[wr_cnt]  = cyc;
      wr_cnt++;
    end
    if (uart_chipselect === 1'b1 && uart_read === 1'b1 && rd_cnt < 64) begin
      rd_addr[rd_cnt] = uart_address;
      rd_be[rd_cnt]   = uart_byteenable;
      rd_cyc[rd_cnt]  = cyc;
      rd_cnt++;
    end
    if ((|req_ready) === 1'b1 && rdy_cnt < 64) begin
      rdy_vec[rdy_cnt] = req_ready;
      rdy_cyc[rdy_cnt] = cyc;
      rdy_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int wb, rb, yb;

    // Reset with all requesters asserting
    hold_all = 1'b1;
    reset_n  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_outputs", outs, 64'h0);
    chk("rst_reads", 64'(rd_cnt), 64'd0);
    chk("rst_writes", 64'(wr_cnt), 64'd0);
    hold_all = 1'b0;

    // Single byte
    do_reset();
    ws = 8'd128;
    rb = rd_cnt; wb = wr_cnt; yb = rdy_cnt;
    push(0, 8'h41, 1'b1);
    wait_writes(wb + 1);
    wait_idle();
    chk("t2_read_count", 64'(rd_cnt - rb), 64'd1);
    chk("t2_read_addr", 64'(rd_addr[rb]), 64'd1);
    chk("t2_read_be", 64'(rd_be[rb]), 64'd0);
    chk("t2_write_count", 64'(wr_cnt - wb), 64'd1);
    chk("t2_write_addr", 64'(wr_addr[wb]), 64'd0);
    chk("t2_write_be", 64'(wr_be[wb]), 64'b0001);
    chk("t2_write_data", 64'(wr_data[wb]), 64'h41);
    chk("t2_grant", 64'(wr_gid[wb]), 64'd0);
    chk("t2_latency", 64'(wr_cyc[wb] - rd_cyc[rb]), 64'd3);
    chk("t2_ready_count", 64'(rdy_cnt - yb), 64'd1);
    chk("t2_ready_vec", 64'(rdy_vec[yb]), 64'b0001);
    chk("t2_ready_cycle", 64'(rdy_cyc[yb] - rd_cyc[rb]), 64'd3);

    // Round robin over four single-byte packets
    do_reset();
    ws = 8'd200;
    wb = wr_cnt; yb = rdy_cnt;
    push(0, 8'h10, 1'b1); push(0, 8'h50, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    wait_writes(wb + 5);
    wait_idle();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3_grant%0d", k), 64'(wr_gid[wb+k]), 64'(k % 4));
      chk($sformatf("t3_data%0d", k), 64'(wr_data[wb+k]), (k < 4) ? 64'(8'h10 + k) : 64'h50);
      chk($sformatf("t3_ready%0d", k), 64'(rdy_vec[yb+k]), 64'(4'b0001 << (k % 4)));
    end
    chk("t3_spacing", 64'(wr_cyc[wb+4] - wr_cyc[wb+3]), 64'd2);

    // Packet lock: req0 arrives mid-packet and must not preempt req1
    do_reset();
    ws = 8'd200;
    wb = wr_cnt;
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(2, 8'hB0, 1'b1);
    wait_writes(wb + 1);
    push(0, 8'hC0, 1'b1);
    wait_writes(wb + 5);
    wait_idle();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_grant%0d", k), 64'(wr_gid[wb+k]), 64'(t4_id[k]));
      chk($sformatf("t4_data%0d", k), 64'(wr_data[wb+k]), 64'(t4_data[k]));
    end
    chk("t4_spacing", 64'(wr_cyc[wb+1] - wr_cyc[wb]), 64'd2);

    // Credit exhaustion and re-polling
    do_reset();
    ws = 8'd2;
    rb = rd_cnt; wb = wr_cnt;
    for (int k = 0; k < 5; k++) push(0, 8'hD0 + 8'(k), k == 4);
    wait_writes(wb + 2);
    ws = 8'd0;
    wait_reads(rb + 3);
    @(posedge clk); #1;
    chk("t5_held_writes", 64'(wr_cnt - wb), 64'd2);
    ws = 8'd3;
    wait_writes(wb + 5);
    wait_idle();
    for (int k = 0; k < 5; k++)
      chk($sformatf("t5_data%0d", k), 64'(wr_data[wb+k]), 64'(8'hD0 + k));
    chk("t5_gap_to_poll", 64'(rd_cyc[rb+1] - wr_cyc[wb+1]), 64'd4);
    chk("t5_repoll_period", 64'(rd_cyc[rb+2] - rd_cyc[rb+1]), 64'd5);
    chk("t5_resume_latency", 64'(wr_cyc[wb+2] - rd_cyc[rb+3]), 64'd3);
    chk("t5_read_count", 64'(rd_cnt - rb), 64'd4);
    chk("t5_write_count", 64'(wr_cnt - wb), 64'd5);

    // Reset during a locked packet's write
    do_reset();
    ws = 8'd200;
    push(1, 8'hE0, 1'b0); push(1, 8'hE1, 1'b0); push(1, 8'hE2, 1'b1);
    wait_write_strobe();
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_outputs", outs, 64'h0);
    @(posedge clk); #1;
    chk("t6_outputs_hold", outs, 64'h0);
    push(2, 8'hF0, 1'b1);
    wb = wr_cnt; rb = rd_cnt;
    reset_n = 1'b1;
    wait_writes(wb + 3);
    wait_idle();
    chk("t6_repoll", 64'(wr_cyc[wb] - rd_cyc[rb]), 64'd3);
    chk("t6_grant0", 64'(wr_gid[wb]), 64'd1);
    chk("t6_data0", 64'(wr_data[wb]), 64'hE1);
    chk("t6_grant1", 64'(wr_gid[wb+1]), 64'd1);
    chk("t6_data1", 64'(wr_data[wb+1]), 64'hE2);
    chk("t6_grant2", 64'(wr_gid[wb+2]), 64'd2);
    chk("t6_data2", 64'(wr_data[wb+2]), 64'hF0);

    // enable=0 blocks new grants; leftover credits avoid a poll afterwards
    enable = 1'b0;
    wb = wr_cnt; rb = rd_cnt;
    push(2, 8'h77, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("t7_blocked_writes", 64'(wr_cnt - wb), 64'd0);
    chk("t7_blocked_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    wait_writes(wb + 1);
    wait_idle();
    chk("t7_grant", 64'(wr_gid[wb]), 64'd2);
    chk("t7_data", 64'(wr_data[wb]), 64'h77);
    chk("t7_no_poll", 64'(rd_cnt - rb), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
